// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: counting modes,
// counter direction and the default counter width.
package pwm_pkg;

    localparam int PWM_CNT_W_DEFAULT = 8;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM compare channel: shadowed duty/polarity, compare against the next
// counter value and a registered, polarity-corrected output.
module pwm_chan_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             cmp_en_i,
    input  logic [CNT_W-1:0] cnt_next_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             pol_i,
    output logic             pwm_o
);

    logic [CNT_W-1:0] act_duty_q;
    logic [CNT_W-1:0] eff_duty;
    logic             act_pol_q;
    logic             eff_pol;
    logic             pwm_d;
    logic             pwm_q;

    // Values being loaded this cycle already govern the cnt==0 output.
    always_comb begin
        eff_duty = load_i ? duty_i : act_duty_q;
        eff_pol  = load_i ? pol_i  : act_pol_q;
        pwm_d    = (cmp_en_i && (cnt_next_i < eff_duty)) ^ eff_pol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_duty_q <= '0;
            act_pol_q  <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            act_duty_q <= eff_duty;
            act_pol_q  <= eff_pol;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared edge/center-aligned period counter,
// glitch-free shadow transfer at period boundaries, NUM_CH compare channels.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W  = PWM_CNT_W_DEFAULT,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    center_mode,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH-1:0]       polarity,
    input  logic                    load_req,
    output logic                    load_ack,
    output logic                    period_end,
    output logic [NUM_CH-1:0]       pwm_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    pwm_dir_e         dir_q, dir_d;
    logic [CNT_W-1:0] act_period_q, eff_period;
    pwm_mode_e        act_mode_q, eff_mode;
    logic             pending_q, pending_d;
    logic             load_ack_q, period_end_q;
    logic             boundary, load_now, load_en, cmp_en;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
        cnt_d   = '0;
        dir_d   = dir_q;
        if (act_period_q == '0) begin
            dir_d = DIR_UP;
        end else if (act_mode_q == PWM_EDGE) begin
            cnt_d = (cnt_inc >= {1'b0, act_period_q}) ? '0 : cnt_inc[CNT_W-1:0];
            dir_d = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            // Clamp at the top of the triangle and turn around.
            if (cnt_inc >= {1'b0, act_period_q}) begin
                cnt_d = act_period_q;
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end else if (cnt_q <= CNT_W'(1)) begin
            dir_d = DIR_UP;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (!en) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end

        // Edge mode with period 1 sits at 0 yet wraps every cycle.
        boundary = en && (cnt_d == '0) &&
                   ((cnt_q != '0) || (act_mode_q == PWM_EDGE && act_period_q == CNT_W'(1)));
        load_now = boundary && (pending_q || load_req);
        load_en  = !en || load_now;
        if (load_now) begin
            dir_d = DIR_UP;
        end

        eff_period = load_en ? period : act_period_q;
        eff_mode   = load_en ? pwm_mode_e'(center_mode) : act_mode_q;
        cmp_en     = en && (eff_period != '0);

        pending_d = pending_q;
        if (!en || load_now) begin
            pending_d = 1'b0;
        end else if (load_req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            act_period_q <= '0;
            act_mode_q   <= PWM_EDGE;
            pending_q    <= 1'b0;
            load_ack_q   <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            act_period_q <= eff_period;
            act_mode_q   <= eff_mode;
            pending_q    <= pending_d;
            load_ack_q   <= load_now;
            period_end_q <= boundary;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pwm_chan_cmp #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load_en),
            .cmp_en_i  (cmp_en),
            .cnt_next_i(cnt_d),
            .duty_i    (duty[i*CNT_W +: CNT_W]),
            .pol_i     (polarity[i]),
            .pwm_o     (pwm_out[i])
        );
    end

    assign load_ack   = load_ack_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: phase-index reference model compared every cycle,
// plus per-scenario pulse-count checks derived from the PWM rules.
module tb_pwm_multi_gen;

    localparam int CNT_W  = 8;
    localparam int NUM_CH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    center_mode;
    logic [CNT_W-1:0]        period;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [NUM_CH-1:0]       polarity;
    logic                    load_req;
    logic                    load_ack;
    logic                    period_end;
    logic [NUM_CH-1:0]       pwm_out;

    int errors = 0;
    int checks = 0;

    // Reference model state: position within one repetition, active settings.
    int          m_pos;
    int          m_period;
    bit          m_center;
    int          m_duty[NUM_CH];
    logic [NUM_CH-1:0] m_pol;
    logic [NUM_CH-1:0] m_pwm;
    logic        m_pe, m_ack, m_pend;

    pwm_multi_gen #(
        .CNT_W (CNT_W),
        .NUM_CH(NUM_CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .center_mode(center_mode),
        .period     (period),
        .duty       (duty),
        .polarity   (polarity),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .period_end (period_end),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pos = 0; m_period = 0; m_center = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
        m_pol = '0; m_pwm = '0; m_pe = 1'b0; m_ack = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_load();
        m_period = int'(period);
        m_center = center_mode;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty[i*CNT_W +: CNT_W]);
        m_pol = polarity;
    endtask

    function automatic int cnt_of(input int pos);
        if (!m_center || pos <= m_period) return pos;
        return 2 * m_period - pos;
    endfunction

    task automatic model_step();
        int  len, np;
        bit  wrap, ld;
        if (rst) begin
            model_reset();
            return;
        end
        if (!en) begin
            model_load();
            m_pos = 0; m_pend = 1'b0; m_pe = 1'b0; m_ack = 1'b0;
            m_pwm = m_pol;
            return;
        end
        len  = (m_period == 0) ? 0 : (m_center ? 2 * m_period : m_period);
        np   = (len == 0) ? 0 : (m_pos + 1) % len;
        wrap = (len != 0) && (np == 0);
        ld   = wrap && (m_pend || load_req);
        if (ld) begin
            model_load();
            m_pend = 1'b0;
        end else if (load_req) begin
            m_pend = 1'b1;
        end
        m_pos = np; m_pe = wrap; m_ack = ld;
        for (int i = 0; i < NUM_CH; i++)
            m_pwm[i] = ((m_period != 0) && (cnt_of(m_pos) < m_duty[i])) ^ m_pol[i];
    endtask

    // One clock: advance DUT and model together, then compare all outputs.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        checks++;
        if ({pwm_out, period_end, load_ack} !== {m_pwm, m_pe, m_ack}) begin
            errors++;
            $display("FAIL %s_model t=%0t pwm_out=%b period_end=%b load_ack=%b expected %b %b %b",
                     tag, $time, pwm_out, period_end, load_ack, m_pwm, m_pe, m_ack);
        end
    endtask

    task automatic set_cfg(input logic cm, input int p, input int d0, input int d1,
                           input int d2, input int d3, input logic [NUM_CH-1:0] pol);
        center_mode = cm;
        period      = CNT_W'(p);
        duty        = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
        polarity    = pol;
    endtask

    task automatic load_idle(input string tag);
        en = 1'b0;
        tick(tag);
        en = 1'b1;
    endtask

    task automatic wait_pe(input string tag, input int bound);
        bit seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            tick(tag);
            seen = (period_end === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_sync period_end not seen within %0d cycles", tag, bound);
        end
    endtask

    // Counts start with the current cycle's outputs.
    task automatic count_window(input string tag, input int n,
                                output int h[NUM_CH], output int pe_n);
        for (int i = 0; i < NUM_CH; i++) h[i] = 0;
        pe_n = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick(tag);
            for (int i = 0; i < NUM_CH; i++) h[i] += int'(pwm_out[i]);
            pe_n += int'(period_end);
        end
    endtask

    task automatic test_reset();
        tick("reset");
        tick("reset");
        checks++;
        if (pwm_out !== '0) begin
            errors++; $display("FAIL reset_pwm got=%b want=0000", pwm_out);
        end
        checks++;
        if (period_end !== 1'b0) begin
            errors++; $display("FAIL reset_period_end got=%b want=0", period_end);
        end
        checks++;
        if (load_ack !== 1'b0) begin
            errors++; $display("FAIL reset_load_ack got=%b want=0", load_ack);
        end
        rst = 1'b0;
    endtask

    task automatic test_edge();
        int h[NUM_CH];
        int pe_n;
        set_cfg(1'b0, 5, 2, 0, 5, 7, 4'b0000);
        load_idle("edge");
        wait_pe("edge", 20);
        count_window("edge", 20, h, pe_n);
        checks++;
        if (h[0] != 8 || h[1] != 0 || h[2] != 20 || h[3] != 20) begin
            errors++;
            $display("FAIL edge_duty high counts got=%0d,%0d,%0d,%0d want=8,0,20,20", h[0], h[1], h[2], h[3]);
        end
        checks++;
        if (pe_n != 4) begin
            errors++; $display("FAIL edge_period_end got=%0d want=4", pe_n);
        end
    endtask

    task automatic test_center();
        int h[NUM_CH];
        int pe_n;
        set_cfg(1'b1, 4, 2, 4, 0, 9, 4'b0000);
        load_idle("center");
        wait_pe("center", 20);
        count_window("center", 16, h, pe_n);
        checks++;
        if (h[0] != 6 || h[1] != 14 || h[2] != 0 || h[3] != 16) begin
            errors++;
            $display("FAIL center_duty high counts got=%0d,%0d,%0d,%0d want=6,14,0,16", h[0], h[1], h[2], h[3]);
        end
        checks++;
        if (pe_n != 2) begin
            errors++; $display("FAIL center_period_end got=%0d want=2", pe_n);
        end
    endtask

    task automatic test_shadow();
        int per[3] = '{0, 0, 0};
        int acks = 0;
        int ack_k = -1;
        set_cfg(1'b0, 10, 3, 0, 0, 0, 4'b0000);
        load_idle("shadow");
        wait_pe("shadow", 20);
        for (int k = 0; k < 30; k++) begin
            if (k > 0) tick("shadow");
            per[k / 10] += int'(pwm_out[0]);
            if (load_ack === 1'b1) begin
                acks++; ack_k = k;
            end
            if (k == 4) begin
                duty[CNT_W-1:0] = CNT_W'(7);
                load_req = 1'b1;
            end else if (k == 5) begin
                load_req = 1'b0;
            end
        end
        checks++;
        if (per[0] != 3 || per[1] != 7 || per[2] != 7) begin
            errors++;
            $display("FAIL shadow_pulses got=%0d,%0d,%0d want=3,7,7", per[0], per[1], per[2]);
        end
        checks++;
        if (acks != 1 || ack_k != 10) begin
            errors++;
            $display("FAIL shadow_load_ack got count=%0d at=%0d want count=1 at=10", acks, ack_k);
        end
    endtask

    task automatic test_back_to_back();
        int per[3] = '{0, 0, 0};
        int ack_at[2] = '{-1, -1};
        int acks = 0;
        set_cfg(1'b0, 6, 1, 0, 0, 0, 4'b0000);
        load_idle("b2b");
        wait_pe("b2b", 20);
        for (int k = 0; k < 18; k++) begin
            if (k > 0) tick("b2b");
            per[k / 6] += int'(pwm_out[0]);
            if (load_ack === 1'b1) begin
                if (acks < 2) ack_at[acks] = k;
                acks++;
            end
            if (k == 5) begin
                duty[CNT_W-1:0] = CNT_W'(4);
                load_req = 1'b1;
            end else if (k == 6) begin
                duty[CNT_W-1:0] = CNT_W'(2);
            end else if (k == 7) begin
                load_req = 1'b0;
            end
        end
        checks++;
        if (per[0] != 1 || per[1] != 4 || per[2] != 2) begin
            errors++;
            $display("FAIL b2b_pulses got=%0d,%0d,%0d want=1,4,2", per[0], per[1], per[2]);
        end
        checks++;
        if (acks != 2 || ack_at[0] != 6 || ack_at[1] != 12) begin
            errors++;
            $display("FAIL b2b_load_ack got count=%0d at=%0d,%0d want count=2 at=6,12",
                     acks, ack_at[0], ack_at[1]);
        end
    endtask

    task automatic test_polarity();
        int h[NUM_CH];
        int pe_n;
        int bad = 0;
        set_cfg(1'b0, 5, 2, 3, 0, 1, 4'b0001);
        load_idle("pol");
        checks++;
        if (pwm_out !== 4'b0001) begin
            errors++; $display("FAIL pol_idle got=%b want=0001", pwm_out);
        end
        wait_pe("pol", 20);
        count_window("pol", 5, h, pe_n);
        checks++;
        if (h[0] != 3 || h[1] != 3 || h[3] != 1) begin
            errors++;
            $display("FAIL pol_duty high counts got=%0d,%0d,%0d want=3,3,1", h[0], h[1], h[3]);
        end
        en = 1'b0;
        tick("pol");
        checks++;
        if (pwm_out !== 4'b0001 || period_end !== 1'b0) begin
            errors++;
            $display("FAIL pol_disable got=%b,%b want=0001,0", pwm_out, period_end);
        end
        period = '0;
        load_idle("pol");
        for (int k = 0; k < 12; k++) begin
            tick("pol");
            if (pwm_out !== 4'b0001 || period_end !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL pol_period0 got=%0d bad cycles want=0", bad);
        end
    endtask

    task automatic test_wrap();
        int h[NUM_CH];
        int pe_n;
        set_cfg(1'b0, 255, 254, 255, 0, 1, 4'b0000);
        load_idle("wrap");
        wait_pe("wrap", 300);
        count_window("wrap", 255, h, pe_n);
        checks++;
        if (h[0] != 254 || h[1] != 255 || h[2] != 0 || h[3] != 1 || pe_n != 1) begin
            errors++;
            $display("FAIL wrap_counts got=%0d,%0d,%0d,%0d pe=%0d want=254,255,0,1 pe=1",
                     h[0], h[1], h[2], h[3], pe_n);
        end
    endtask

    task automatic test_reset_mid();
        int h[NUM_CH];
        int pe_n;
        set_cfg(1'b1, 4, 2, 3, 0, 0, 4'b1100);
        load_idle("rstmid");
        wait_pe("rstmid", 20);
        repeat (5) tick("rstmid");
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (pwm_out !== '0 || period_end !== 1'b0 || load_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async got=%b,%b,%b want=0000,0,0", pwm_out, period_end, load_ack);
        end
        model_reset();
        tick("rstmid");
        tick("rstmid");
        rst = 1'b0;
        repeat (3) tick("rstmid");
        checks++;
        if (pwm_out !== '0 || period_end !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle got=%b,%b want=0000,0", pwm_out, period_end);
        end
        load_idle("rstmid");
        wait_pe("rstmid", 20);
        count_window("rstmid", 8, h, pe_n);
        checks++;
        if (h[0] != 3 || h[1] != 5 || h[2] != 8 || pe_n != 1) begin
            errors++;
            $display("FAIL rstmid_restart got=%0d,%0d,%0d pe=%0d want=3,5,8 pe=1",
                     h[0], h[1], h[2], pe_n);
        end
    endtask

    task automatic test_random();
        set_cfg(1'b0, 6, 2, 4, 6, 1, 4'b0101);
        load_idle("random");
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                        int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                        4'($urandom_range(0, 15)));
            end
            load_req = ($urandom_range(0, 5) == 0);
            en       = ($urandom_range(0, 39) != 0);
            tick("random");
        end
        load_req = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load_req = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0, 0, 4'b0000);
        model_reset();
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_back_to_back();
        test_polarity();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Multi-channel, parametrised PWM generator: one shared period counter drives NUM_CH independent compare channels.
- Adds over the single-channel generator: edge- or center-aligned counting, per-channel output polarity, and shadow registers so period/duty/mode/polarity change only at a period boundary (glitch-free).
- Sits in the peripheral/timer area and feeds motor, LED and servo outputs directly.

Parameters:
CNT_W, 8, width of counter, period and each duty value
NUM_CH, 4, number of PWM channels (1..16)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  run enable; low holds counter at 0 and outputs inactive
center_mode  in  1  0 = edge-aligned, 1 = center-aligned (shadowed)
period  in  CNT_W  period value (shadowed)
duty  in  NUM_CH*CNT_W  per-channel duty; channel i at bits [i*CNT_W +: CNT_W] (shadowed)
polarity  in  NUM_CH  per-channel invert; 1 = active-low output (shadowed)
load_req  in  1  one-cycle request to transfer shadow inputs at next boundary
load_ack  out  1  one-cycle pulse in the cycle active registers take new values
period_end  out  1  one-cycle pulse when counter returns to 0
pwm_out  out  NUM_CH  PWM outputs

Behaviour:
- Reset (async, rst=1): cnt=0, dir=up, active period/duty/mode/polarity=0, pending=0, pwm_out=0, load_ack=0, period_end=0.
- en=0: cnt held 0, dir=up, pending cleared, active regs load inputs every cycle, pwm_out[i]=active polarity[i] (inactive level), pulses 0.
- Edge mode: cnt_next = (cnt+1 >= act_period) ? 0 : cnt+1; repetition = act_period cycles.
- Center mode: triangle. Up 0..act_period, then down to 0, dir flips at ends; repetition = 2*act_period cycles.
- act_period=0 (either mode): cnt stays 0, all channels inactive, period_end never pulses.
- Boundary: cycle in which cnt_next==0 while cnt!=0 (or cnt==0 with act_period==1 in edge mode). period_end is registered and asserts in the cycle cnt==0 follows the boundary.
- Compare: raw_i = (cnt_next < act_duty_i).
  - duty=0 gives 0%; duty>=period gives 100% in edge mode.
  - Center mode gives (2*duty-1) active cycles per 2*period, centered on cnt=0.
- pwm_out[i] <= raw_i XOR act_polarity[i], registered, so pwm_out is aligned with cnt with no extra latency.
- Shadow transfer:
  - load_req sets pending.
  - At a boundary with (pending | load_req), the active regs sample the current period/duty/center_mode/polarity inputs, pending clears, and load_ack pulses in the next cycle.
  - The new values govern the cycle where cnt==0.
  - load_req in the same cycle as a boundary applies at that boundary.
  - Repeated load_req while pending has no extra effect.
- Mode change at a boundary restarts at cnt=0, dir=up.
- en falling mid-period: next cycle cnt=0 and outputs inactive. en rising: counting starts from 0 with the values loaded in the last en=0 cycle.
- Reset mid-operation: immediate return to reset values regardless of state.
- Widths: all compares unsigned CNT_W. cnt+1 is computed at CNT_W+1 bits, so period = 2^CNT_W-1 wraps correctly.

Decomposition:
- Package pwm_pkg: mode constants PWM_EDGE=1'b0, PWM_CENTER=1'b1; default CNT_W.
- Sub-module pwm_chan_cmp (one per channel, generate loop) holds the shadow→active duty/polarity registers, the compare, polarity XOR and output register.
- Top level holds the counter, direction, pending/load logic and boundary pulse.

Test Plan:
- Edge, period=5, duty0=2, duty1=0, duty2=5, duty3=7, pol=0, en=1 -> ch0 high 2 of every 5 cycles; ch1 always 0; ch2 and ch3 always 1; period_end every 5 cycles.
- Center, period=4, duty0=2 -> cnt 0,1,2,3,4,3,2,1 repeating; ch0 high when cnt in {1,0,1} (3 of 8); period_end every 8 cycles.
- Edge period=10, duty0=3, then duty0=7 with load_req mid-period -> ch0 keeps 3-cycle pulses until the next cnt==0; load_ack pulses once; next period has 7 cycles high, with no short or extra pulse.
- polarity=4'b0001, duty0=2, period=5, loaded -> ch0 low 2 of 5 cycles; en=0 forces ch0=1 and others 0; period=0 gives the same inactive levels.
- load_req asserted exactly in the boundary cycle -> new values apply at that cnt==0; a second load_req one cycle later waits for the following boundary.
- rst pulsed mid-period in center mode with dir=down -> all outputs 0 immediately; after release with en=1, counting restarts from 0 going up.
